// File: rtl/vpu_operand_fetch_seq_if.sv
// Handshake bundle between the request FIFO, the SRAM read ports and the
// execution stage for the VPU operand fetch sequencer.
interface vpu_operand_fetch_seq_if #(
    parameter int SRC_CNT  = 3,
    parameter int ADDR_W   = 32,
    parameter int OPC_W    = 8,
    parameter int BANK_LG2 = 2,
    parameter int ROW_LG2  = 10,
    parameter int DLY_W    = 3,
    parameter int CNT_W    = 16
);
    logic                                in_valid;
    logic                                in_ready;
    logic [OPC_W+(SRC_CNT+1)*ADDR_W-1:0] in_instr;
    logic [SRC_CNT-1:0]                  rd_valid;
    logic [SRC_CNT*BANK_LG2-1:0]         rd_bank;
    logic [SRC_CNT*ROW_LG2-1:0]          rd_row;
    logic                                rd_ready;
    logic                                op_valid;
    logic                                op_ready;
    logic [OPC_W-1:0]                    op_opcode;
    logic [1:0]                          op_src_cnt;
    logic [DLY_W-1:0]                    op_delay;
    logic [BANK_LG2-1:0]                 op_dst_bank;
    logic [ROW_LG2-1:0]                  op_dst_row;
    logic                                err_illegal;
    logic [CNT_W-1:0]                    conflict_cnt;

    modport slave (
        input  in_valid, in_instr, rd_ready, op_ready,
        output in_ready, rd_valid, rd_bank, rd_row, op_valid, op_opcode,
               op_src_cnt, op_delay, op_dst_bank, op_dst_row, err_illegal,
               conflict_cnt
    );

    modport master (
        output in_valid, in_instr, rd_ready, op_ready,
        input  in_ready, rd_valid, rd_bank, rd_row, op_valid, op_opcode,
               op_src_cnt, op_delay, op_dst_bank, op_dst_row, err_illegal,
               conflict_cnt
    );
endinterface

// File: rtl/vpu_operand_fetch_seq.sv
// VPU operand fetch sequencer: decodes one instruction, issues bank-conflict-free
// groups of SRAM source reads, then presents the decoded op to the exec stage.
module vpu_operand_fetch_seq #(
    parameter int SRC_CNT    = 3,
    parameter int ADDR_W     = 32,
    parameter int OPC_W      = 8,
    parameter int BANK_CNT   = 4,
    parameter int BANK_DEPTH = 1024,
    parameter int DATA_W     = 512,
    parameter int DLY_W      = 3,
    parameter int CNT_W      = 16
) (
    input logic                   clk,
    input logic                   rst,
    vpu_operand_fetch_seq_if.slave bus
);
    localparam int BANK_LG2 = $clog2(BANK_CNT);
    localparam int ROW_LG2  = $clog2(BANK_DEPTH);
    localparam int DW_LG2   = $clog2(DATA_W);
    localparam int BANK_LSB = DW_LG2;
    localparam int ROW_LSB  = DW_LG2 + BANK_LG2;
    localparam int INSTR_W  = OPC_W + (SRC_CNT + 1) * ADDR_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_OP_OUT = 2'd2;

    typedef struct packed {
        logic             legal;
        logic [1:0]       src_cnt;
        logic [DLY_W-1:0] delay;
    } dec_t;

    function automatic logic [BANK_LG2-1:0] addr_bank(input logic [ADDR_W-1:0] a);
        return a[BANK_LSB +: BANK_LG2];
    endfunction

    function automatic logic [ROW_LG2-1:0] addr_row(input logic [ADDR_W-1:0] a);
        return a[ROW_LSB +: ROW_LG2];
    endfunction

    function automatic dec_t decode_opc(input logic [OPC_W-1:0] opc);
        dec_t d;
        d.legal   = 1'b1;
        d.src_cnt = 2'd0;
        d.delay   = '0;
        case (opc)
            OPC_W'(8'h01): begin d.src_cnt = 2'd2; d.delay = DLY_W'(3'd2); end
            OPC_W'(8'h02): begin d.src_cnt = 2'd2; d.delay = DLY_W'(3'd2); end
            OPC_W'(8'h03): begin d.src_cnt = 2'd2; d.delay = DLY_W'(3'd3); end
            OPC_W'(8'h04): begin d.src_cnt = 2'd2; d.delay = DLY_W'(3'd6); end
            OPC_W'(8'h05): begin d.src_cnt = 2'd3; d.delay = DLY_W'(3'd4); end
            OPC_W'(8'h06): begin d.src_cnt = 2'd1; d.delay = DLY_W'(3'd5); end
            OPC_W'(8'h07): begin d.src_cnt = 2'd1; d.delay = DLY_W'(3'd5); end
            OPC_W'(8'h08): begin d.src_cnt = 2'd2; d.delay = DLY_W'(3'd1); end
            OPC_W'(8'h09): begin d.src_cnt = 2'd3; d.delay = DLY_W'(3'd2); end
            OPC_W'(8'h0A): begin d.src_cnt = 2'd2; d.delay = DLY_W'(3'd3); end
            OPC_W'(8'h0B): begin d.src_cnt = 2'd3; d.delay = DLY_W'(3'd5); end
            OPC_W'(8'h0C): begin d.src_cnt = 2'd1; d.delay = DLY_W'(3'd7); end
            default:       begin d.legal   = 1'b0; end
        endcase
        return d;
    endfunction

    function automatic logic [SRC_CNT-1:0] used_mask(input logic [1:0] n);
        logic [SRC_CNT-1:0] m;
        m = '0;
        for (int i = 0; i < SRC_CNT; i++) begin
            m[i] = (i < int'(n)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Greedy in index order: lowest pending source always wins its bank,
    // later sources join only if their bank is still free this cycle.
    function automatic logic [SRC_CNT-1:0] select_group(
        input logic [SRC_CNT-1:0]          pend,
        input logic [SRC_CNT*BANK_LG2-1:0] banks
    );
        logic [SRC_CNT-1:0]  g;
        logic [BANK_CNT-1:0] used;
        logic [BANK_LG2-1:0] b;
        g    = '0;
        used = '0;
        for (int i = 0; i < SRC_CNT; i++) begin
            b = banks[i*BANK_LG2 +: BANK_LG2];
            if (pend[i] && !used[b]) begin
                g[i]    = 1'b1;
                used[b] = 1'b1;
            end
        end
        return g;
    endfunction

    logic [1:0]                  r_state;
    logic [SRC_CNT-1:0]          r_pend;
    logic [SRC_CNT*BANK_LG2-1:0] r_src_bank;
    logic [SRC_CNT*ROW_LG2-1:0]  r_src_row;
    logic [SRC_CNT-1:0]          r_rd_valid;
    logic [SRC_CNT*BANK_LG2-1:0] r_rd_bank;
    logic [SRC_CNT*ROW_LG2-1:0]  r_rd_row;
    logic                        r_in_ready;
    logic                        r_op_valid;
    logic [OPC_W-1:0]            r_op_opcode;
    logic [1:0]                  r_op_src_cnt;
    logic [DLY_W-1:0]            r_op_delay;
    logic [BANK_LG2-1:0]         r_op_dst_bank;
    logic [ROW_LG2-1:0]          r_op_dst_row;
    logic                        r_err;
    logic [CNT_W-1:0]            r_cnt;

    logic [OPC_W-1:0]            w_opc;
    logic [ADDR_W-1:0]           w_dst_addr;
    dec_t                        w_dec;
    logic                        w_accept;
    logic                        w_illegal;
    logic                        w_issue_done;
    logic [1:0]                  w_state_nxt;
    logic [SRC_CNT-1:0]          w_pend_nxt;
    logic [SRC_CNT*BANK_LG2-1:0] w_in_bank;
    logic [SRC_CNT*ROW_LG2-1:0]  w_in_row;
    logic [SRC_CNT*BANK_LG2-1:0] w_bank_nxt;
    logic [SRC_CNT*ROW_LG2-1:0]  w_row_nxt;
    logic [SRC_CNT-1:0]          w_grp_nxt;
    logic [SRC_CNT*BANK_LG2-1:0] w_rd_bank_nxt;
    logic [SRC_CNT*ROW_LG2-1:0]  w_rd_row_nxt;

    assign w_opc      = bus.in_instr[INSTR_W-1 -: OPC_W];
    assign w_dst_addr = bus.in_instr[ADDR_W-1:0];
    assign w_dec      = decode_opc(w_opc);

    // Split the incoming source addresses into per-port bank/row fields.
    always_comb begin
        w_in_bank = '0;
        w_in_row  = '0;
        for (int i = 0; i < SRC_CNT; i++) begin
            w_in_bank[i*BANK_LG2 +: BANK_LG2] = addr_bank(bus.in_instr[(i+1)*ADDR_W +: ADDR_W]);
            w_in_row[i*ROW_LG2 +: ROW_LG2]    = addr_row(bus.in_instr[(i+1)*ADDR_W +: ADDR_W]);
        end
    end

    assign w_accept     = (r_state == S_IDLE) && bus.in_valid && w_dec.legal;
    assign w_illegal    = (r_state == S_IDLE) && bus.in_valid && !w_dec.legal;
    assign w_issue_done = (r_state == S_ISSUE) && bus.rd_ready;

    // Next-state and pending-mask update.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                    w_pend_nxt  = used_mask(w_dec.src_cnt);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (bus.rd_ready) begin
                    w_pend_nxt  = r_pend & ~r_rd_valid;
                    w_state_nxt = (w_pend_nxt == '0) ? S_OP_OUT : S_ISSUE;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_OP_OUT: begin
                if (bus.op_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_OP_OUT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

    // The group for the coming cycle is precomputed so rd_* leave a register;
    // a new instruction's banks are used in the cycle it is accepted.
    always_comb begin
        w_bank_nxt    = w_accept ? w_in_bank : r_src_bank;
        w_row_nxt     = w_accept ? w_in_row  : r_src_row;
        w_grp_nxt     = '0;
        w_rd_bank_nxt = '0;
        w_rd_row_nxt  = '0;
        if (w_state_nxt == S_ISSUE) begin
            w_grp_nxt = select_group(w_pend_nxt, w_bank_nxt);
        end else begin
            w_grp_nxt = '0;
        end
        for (int i = 0; i < SRC_CNT; i++) begin
            if (w_grp_nxt[i]) begin
                w_rd_bank_nxt[i*BANK_LG2 +: BANK_LG2] = w_bank_nxt[i*BANK_LG2 +: BANK_LG2];
                w_rd_row_nxt[i*ROW_LG2 +: ROW_LG2]    = w_row_nxt[i*ROW_LG2 +: ROW_LG2];
            end else begin
                w_rd_bank_nxt[i*BANK_LG2 +: BANK_LG2] = '0;
                w_rd_row_nxt[i*ROW_LG2 +: ROW_LG2]    = '0;
            end
        end
    end

    // Sequencer state, latched instruction fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pend        <= '0;
            r_src_bank    <= '0;
            r_src_row     <= '0;
            r_rd_valid    <= '0;
            r_rd_bank     <= '0;
            r_rd_row      <= '0;
            r_in_ready    <= 1'b1;
            r_op_valid    <= 1'b0;
            r_op_opcode   <= '0;
            r_op_src_cnt  <= 2'd0;
            r_op_delay    <= '0;
            r_op_dst_bank <= '0;
            r_op_dst_row  <= '0;
            r_err         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_src_bank <= w_bank_nxt;
            r_src_row  <= w_row_nxt;
            r_rd_valid <= w_grp_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_rd_row   <= w_rd_row_nxt;
            r_in_ready <= (w_state_nxt == S_IDLE);
            r_op_valid <= (w_state_nxt == S_OP_OUT);
            r_err      <= w_illegal;
            if (w_accept) begin
                r_op_opcode   <= w_opc;
                r_op_src_cnt  <= w_dec.src_cnt;
                r_op_delay    <= w_dec.delay;
                r_op_dst_bank <= addr_bank(w_dst_addr);
                r_op_dst_row  <= addr_row(w_dst_addr);
            end
            if (w_issue_done && (w_pend_nxt != '0) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_bank      = r_rd_bank;
    assign bus.rd_row       = r_rd_row;
    assign bus.op_valid     = r_op_valid;
    assign bus.op_opcode    = r_op_opcode;
    assign bus.op_src_cnt   = r_op_src_cnt;
    assign bus.op_delay     = r_op_delay;
    assign bus.op_dst_bank  = r_op_dst_bank;
    assign bus.op_dst_row   = r_op_dst_row;
    assign bus.err_illegal  = r_err;
    assign bus.conflict_cnt = r_cnt;
endmodule

// File: tb/tb_vpu_operand_fetch_seq.sv
// Self-checking bench for vpu_operand_fetch_seq: directed vector table,
// hand-written reset sequence and randomized instructions against a model.
module tb_vpu_operand_fetch_seq;
    localparam int SRC_CNT = 3;
    localparam int ADDR_W  = 32;
    localparam int OPC_W   = 8;
    localparam int DLY_W   = 3;
    localparam int CNT_W   = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   exp_cnt;

    logic [2:0] obs_first;
    int         obs_groups;
    logic       obs_err;
    logic [1:0] obs_src_cnt;
    logic [2:0] obs_dly;
    logic [1:0] obs_dbank;
    logic [9:0] obs_drow;

    int cnt_tab [16] = '{0, 2, 2, 2, 2, 3, 1, 1, 2, 3, 2, 3, 1, 0, 0, 0};
    int dly_tab [16] = '{0, 2, 2, 3, 6, 4, 5, 5, 1, 2, 3, 5, 7, 0, 0, 0};

    typedef struct {
        logic [7:0]  opc;
        logic [31:0] s0, s1, s2, dst;
        int          rd_stall, op_stall;
        logic        exp_err;
        logic [2:0]  exp_first;
        int          exp_groups;
        logic [1:0]  exp_src_cnt;
        logic [2:0]  exp_dly;
        logic [1:0]  exp_dbank;
        logic [9:0]  exp_drow;
    } vec_t;

    vec_t tbl [7];

    vpu_operand_fetch_seq_if #(
        .SRC_CNT(SRC_CNT), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .BANK_LG2(2),
        .ROW_LG2(10), .DLY_W(DLY_W), .CNT_W(CNT_W)
    ) bus ();

    vpu_operand_fetch_seq #(
        .SRC_CNT(SRC_CNT), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .BANK_CNT(4),
        .BANK_DEPTH(1024), .DATA_W(512), .DLY_W(DLY_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int bank_of(input logic [31:0] a);
        return int'((a >> 9) % 32'd4);
    endfunction

    function automatic int row_of(input logic [31:0] a);
        return int'((a >> 11) % 32'd1024);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction and follow it through issue and op hand-off;
    // every rd_valid stall holds rd_ready low for rd_stall cycles per group.
    task automatic run_instr(input logic [7:0] opc, input logic [31:0] s0, s1, s2, d,
                             input int rd_stall, input int op_stall);
        logic [31:0] src [3];
        logic [2:0]  masks [$];
        int          rem [$];
        int          keep [$];
        int          taken [$];
        logic [2:0]  m;
        logic [5:0]  eb;
        logic [29:0] er;
        bit          legal;
        bit          clash;
        int          n, dly, bk;
        src[0] = s0; src[1] = s1; src[2] = s2;
        legal = (opc >= 8'h01) && (opc <= 8'h0C);
        n   = legal ? cnt_tab[opc[3:0]] : 0;
        dly = legal ? dly_tab[opc[3:0]] : 0;
        for (int i = 0; i < n; i++) rem.push_back(i);
        while (rem.size() > 0) begin
            taken.delete();
            keep.delete();
            m = 3'b000;
            foreach (rem[k]) begin
                bk = bank_of(src[rem[k]]);
                clash = 1'b0;
                foreach (taken[t]) if (taken[t] == bk) clash = 1'b1;
                if (clash) keep.push_back(rem[k]);
                else begin
                    m[rem[k]] = 1'b1;
                    taken.push_back(bk);
                end
            end
            masks.push_back(m);
            rem = keep;
        end

        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_instr = {opc, s2, s1, s0, d};
        @(negedge clk);
        bus.in_valid = 1'b0;
        obs_first  = bus.rd_valid;
        obs_err    = bus.err_illegal;
        obs_groups = 0;
        chk("err_illegal", 64'(bus.err_illegal), legal ? 64'd0 : 64'd1);
        if (!legal) begin
            chk("illegal_rd_valid", 64'(bus.rd_valid), 64'd0);
            chk("illegal_op_valid", 64'(bus.op_valid), 64'd0);
            chk("illegal_in_ready", 64'(bus.in_ready), 64'd1);
            @(negedge clk);
            chk("err_pulse_end", 64'(bus.err_illegal), 64'd0);
            chk("illegal_rd_valid2", 64'(bus.rd_valid), 64'd0);
            chk("illegal_op_valid2", 64'(bus.op_valid), 64'd0);
            return;
        end

        foreach (masks[g]) begin
            eb = '0;
            er = '0;
            for (int i = 0; i < 3; i++) begin
                if (masks[g][i]) begin
                    eb[i*2 +: 2]   = 2'(bank_of(src[i]));
                    er[i*10 +: 10] = 10'(row_of(src[i]));
                end
            end
            for (int s = 0; s <= rd_stall; s++) begin
                chk("rd_valid", 64'(bus.rd_valid), 64'(masks[g]));
                chk("rd_bank", 64'(bus.rd_bank), 64'(eb));
                chk("rd_row", 64'(bus.rd_row), 64'(er));
                chk("in_ready_issue", 64'(bus.in_ready), 64'd0);
                chk("op_valid_issue", 64'(bus.op_valid), 64'd0);
                if (s == rd_stall && bus.rd_valid != 3'b000) obs_groups++;
                bus.rd_ready = (s == rd_stall);
                @(negedge clk);
            end
            bus.rd_ready = 1'b0;
        end
        exp_cnt = exp_cnt + masks.size() - 1;
        if (exp_cnt > 65535) exp_cnt = 65535;

        for (int s = 0; s <= op_stall; s++) begin
            chk("op_valid", 64'(bus.op_valid), 64'd1);
            chk("op_opcode", 64'(bus.op_opcode), 64'(opc));
            chk("op_src_cnt", 64'(bus.op_src_cnt), 64'(n));
            chk("op_delay", 64'(bus.op_delay), 64'(dly));
            chk("op_dst_bank", 64'(bus.op_dst_bank), 64'(bank_of(d)));
            chk("op_dst_row", 64'(bus.op_dst_row), 64'(row_of(d)));
            chk("rd_valid_op", 64'(bus.rd_valid), 64'd0);
            chk("in_ready_op", 64'(bus.in_ready), 64'd0);
            chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(exp_cnt));
            if (s == 0) begin
                obs_src_cnt = bus.op_src_cnt;
                obs_dly     = bus.op_delay;
                obs_dbank   = bus.op_dst_bank;
                obs_drow    = bus.op_dst_row;
            end
            bus.op_ready = (s == op_stall);
            @(negedge clk);
        end
        bus.op_ready = 1'b0;
        chk("op_valid_done", 64'(bus.op_valid), 64'd0);
        chk("in_ready_done", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
        chk({tag, "_rd_bank"}, 64'(bus.rd_bank), 64'd0);
        chk({tag, "_rd_row"}, 64'(bus.rd_row), 64'd0);
        chk({tag, "_op_valid"}, 64'(bus.op_valid), 64'd0);
        chk({tag, "_op_opcode"}, 64'(bus.op_opcode), 64'd0);
        chk({tag, "_op_delay"}, 64'(bus.op_delay), 64'd0);
        chk({tag, "_err"}, 64'(bus.err_illegal), 64'd0);
        chk({tag, "_conflict"}, 64'(bus.conflict_cnt), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.rd_ready = 1'b0;
        bus.op_ready = 1'b0;

        tbl[0] = '{opc: 8'h01, s0: 32'h0, s1: 32'h200, s2: 32'h0, dst: 32'h400, rd_stall: 0, op_stall: 0,
                   exp_err: 1'b0, exp_first: 3'b011, exp_groups: 1, exp_src_cnt: 2'd2, exp_dly: 3'd2,
                   exp_dbank: 2'd2, exp_drow: 10'd0};
        tbl[1] = '{opc: 8'h05, s0: 32'h0, s1: 32'h800, s2: 32'h1000, dst: 32'h0, rd_stall: 0, op_stall: 0,
                   exp_err: 1'b0, exp_first: 3'b001, exp_groups: 3, exp_src_cnt: 2'd3, exp_dly: 3'd4,
                   exp_dbank: 2'd0, exp_drow: 10'd0};
        tbl[2] = '{opc: 8'h09, s0: 32'h0, s1: 32'h800, s2: 32'h200, dst: 32'h1E00, rd_stall: 1, op_stall: 0,
                   exp_err: 1'b0, exp_first: 3'b101, exp_groups: 2, exp_src_cnt: 2'd3, exp_dly: 3'd2,
                   exp_dbank: 2'd3, exp_drow: 10'd3};
        tbl[3] = '{opc: 8'h0D, s0: 32'h200, s1: 32'h0, s2: 32'h0, dst: 32'h0, rd_stall: 0, op_stall: 0,
                   exp_err: 1'b1, exp_first: 3'b000, exp_groups: 0, exp_src_cnt: 2'd0, exp_dly: 3'd0,
                   exp_dbank: 2'd0, exp_drow: 10'd0};
        tbl[4] = '{opc: 8'h0C, s0: 32'h1234, s1: 32'h0, s2: 32'h0, dst: 32'h0030_0A00, rd_stall: 3, op_stall: 2,
                   exp_err: 1'b0, exp_first: 3'b001, exp_groups: 1, exp_src_cnt: 2'd1, exp_dly: 3'd7,
                   exp_dbank: 2'd1, exp_drow: 10'h201};
        tbl[5] = '{opc: 8'h04, s0: 32'h200, s1: 32'h200, s2: 32'h0, dst: 32'h600, rd_stall: 0, op_stall: 1,
                   exp_err: 1'b0, exp_first: 3'b001, exp_groups: 2, exp_src_cnt: 2'd2, exp_dly: 3'd6,
                   exp_dbank: 2'd3, exp_drow: 10'd0};
        tbl[6] = '{opc: 8'h06, s0: 32'h1234_5678, s1: 32'h0, s2: 32'h0, dst: 32'h0, rd_stall: 0, op_stall: 0,
                   exp_err: 1'b0, exp_first: 3'b001, exp_groups: 1, exp_src_cnt: 2'd1, exp_dly: 3'd5,
                   exp_dbank: 2'd0, exp_drow: 10'd0};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_instr(tbl[v].opc, tbl[v].s0, tbl[v].s1, tbl[v].s2, tbl[v].dst,
                      tbl[v].rd_stall, tbl[v].op_stall);
            chk("tbl_err", 64'(obs_err), 64'(tbl[v].exp_err));
            chk("tbl_first", 64'(obs_first), 64'(tbl[v].exp_first));
            chk("tbl_groups", 64'(obs_groups), 64'(tbl[v].exp_groups));
            if (!tbl[v].exp_err) begin
                chk("tbl_src_cnt", 64'(obs_src_cnt), 64'(tbl[v].exp_src_cnt));
                chk("tbl_delay", 64'(obs_dly), 64'(tbl[v].exp_dly));
                chk("tbl_dst_bank", 64'(obs_dbank), 64'(tbl[v].exp_dbank));
                chk("tbl_dst_row", 64'(obs_drow), 64'(tbl[v].exp_drow));
            end
        end
        // Conflict extras from the table: FADD3 2, FMAX3 1, FDIV 1.
        chk("tbl_conflict_total", 64'(bus.conflict_cnt), 64'd4);

        for (int r = 0; r < 60; r++) begin
            logic [31:0] a0, a1, a2;
            a0 = $urandom();
            a1 = ($urandom_range(0, 4) == 0) ? a0 : $urandom();
            a2 = $urandom();
            run_instr(8'($urandom_range(0, 14)), a0, a1, a2, $urandom(),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset during the second issue cycle of an all-bank0 FADD3.
        chk("rst_seq_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_instr = {8'h05, 32'h1000, 32'h800, 32'h0, 32'h0};
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst_seq_rd1", 64'(bus.rd_valid), 64'd1);
        bus.rd_ready = 1'b1;
        @(negedge clk);
        chk("rst_seq_rd2", 64'(bus.rd_valid), 64'd2);
        chk("rst_seq_row2", 64'(bus.rd_row), 64'd1 << 10);
        chk("rst_seq_cnt", 64'(bus.conflict_cnt), 64'(exp_cnt + 1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rd_ready = 1'b0;
        exp_cnt = 0;
        chk_all_zero("mid_rst");
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_op", 64'(bus.op_valid), 64'd0);
            chk("mid_rst_no_rd", 64'(bus.rd_valid), 64'd0);
        end

        run_instr(8'h01, 32'h0, 32'h200, 32'h0, 32'h400, 0, 0);
        chk("post_rst_first", 64'(obs_first), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
